// File: rtl/regfile_arbiter_pkg.sv
// rtl/regfile_arbiter_pkg.sv - shared widths, FSM encoding and round-robin pick helper
//
// Holds the default regfile geometry shared by the arbiter and the regfile.
// It also holds the arbiter state encoding and the two-way round-robin pick
// function used by rr_arb2.
package regfile_arbiter_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // One-hot pick from two requesters. A lone requester wins outright.
    // On contention, ptr selects the winner (0 -> requester 0, 1 -> requester 1).
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] pick;
        if (req == 2'b11) begin
            pick = ptr ? 2'b10 : 2'b01;
        end else begin
            pick = req;
        end
        return pick;
    endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - single-port register file with combinational read
//
// Ports:
//   clk, rst : clock, synchronous active-high reset (reset suppresses a pending write)
//   n        : address (read and write)
//   d        : write data
//   w        : write enable, committed at the rising edge
//   q        : combinational read of entry n
module regfile
    import regfile_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] n,
    input  logic [DATA_W-1:0] d,
    input  logic              w,
    output logic [DATA_W-1:0] q
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Contents survive reset. A write that is still pending at a reset edge
    // is dropped, so reset cancels an uncommitted write.
    always_ff @(posedge clk) begin
        if (!rst && w) begin
            mem[n] <= d;
        end
    end

    assign q = mem[n];

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin pick with priority pointer
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : arbitration enabled this cycle; when low, no grant is produced and ptr holds
//   req[1:0]  : request vector {req1, req0}
//   gnt[1:0]  : one-hot combinational grant
module rr_arb2
    import regfile_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr = requester that wins the next tie; it flips to the loser of every grant.
    logic ptr;

    assign gnt = en ? rr_pick(req, ptr) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (gnt[0]) begin
            ptr <= 1'b1;
        end else if (gnt[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester regfile arbiter with lock and pipelined read return
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req0/1, lock0/1     : access request; keep ownership after the current grant
//   we0/1, addr0/1      : write (1) / read (0), target register
//   wdata0/1            : write data
//   gnt0/1              : combinational grant, transfer when req & gnt
//   rvalid0/1, rdata    : read return, valid two cycles after the read grant
//   rf_n, rf_d, rf_w    : registered address / write data / write enable to regfile
//   rf_q                : combinational regfile read data of entry rf_n
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rf_n,
    output logic [DATA_W-1:0] rf_d,
    output logic              rf_w,
    input  logic [DATA_W-1:0] rf_q
);

    arb_state_t state;
    arb_state_t state_nxt;

    logic [1:0] rr_gnt;
    logic       rr_en;

    // Round-robin arbitration only runs in IDLE. Under reset it is disabled,
    // so no grant is issued and the pointer cannot advance.
    assign rr_en = (state == ST_IDLE) && !rst;

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .en  (rr_en),
        .req ({req1, req0}),
        .gnt (rr_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    gnt0 = rr_gnt[0];
                    gnt1 = rr_gnt[1];
                    if (rr_gnt[0] && lock0) begin
                        state_nxt = ST_OWN0;
                    end else if (rr_gnt[1] && lock1) begin
                        state_nxt = ST_OWN1;
                    end
                end
                ST_OWN0: begin
                    // Owner keeps the port. Ownership is released when the owner
                    // stops requesting or makes an unlocked transfer.
                    gnt0 = req0;
                    if (!req0 || !lock0) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_OWN1: begin
                    gnt1 = req1;
                    if (!req1 || !lock1) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Mux the granted requester's command into the regfile stage.
    logic              xfer;
    logic              xfer_we;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_wdata;

    assign xfer       = gnt0 | gnt1;
    assign xfer_we    = gnt0 ? we0    : we1;
    assign xfer_addr  = gnt0 ? addr0  : addr1;
    assign xfer_wdata = gnt0 ? wdata0 : wdata1;

    // Per-port read in flight, one cycle behind the grant.
    logic rd_pend0;
    logic rd_pend1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_n     <= '0;
            rf_d     <= '0;
            rf_w     <= 1'b0;
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
        end else begin
            rf_w     <= xfer & xfer_we;
            rd_pend0 <= gnt0 & ~we0;
            rd_pend1 <= gnt1 & ~we1;
            if (xfer) begin
                rf_n <= xfer_addr;
                rf_d <= xfer_wdata;
            end
        end
    end

    // rf_q reflects rf_n one cycle after the grant. A write granted in the
    // previous cycle has already committed by the time a following read
    // samples rf_q, so the read sees the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= rd_pend0;
            rvalid1 <= rd_pend1;
            if (rd_pend0 || rd_pend1) begin
                rdata <= rf_q;
            end
        end
    end

endmodule
